// File: rtl/mag_comp_serial_if.sv
// mag_comp_serial_if: request/result bundle for the serial magnitude comparator
interface mag_comp_serial_if #(parameter int WIDTH = 16, parameter int CHUNK = 4);
  localparam int CW = $clog2(WIDTH / CHUNK) + 1;
  logic start;
  logic signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic L;
  logic G;
  logic E;
  logic [CW-1:0] steps;
  modport master (output start, signed_mode, a, b, input busy, done, L, G, E, steps);
  modport slave (input start, signed_mode, a, b, output busy, done, L, G, E, steps);
endinterface

// File: rtl/mag_comp_serial.sv
// mag_comp_serial: MSB-first chunked magnitude compare with early exit on the first differing chunk
module mag_comp_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic clk,
  input logic rst,
  mag_comp_serial_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = $clog2(NCHUNK) + 1;
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
  typedef enum logic {IDLE, COMPARE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_r, b_r, a_n, b_n;
  logic [CW-1:0] idx, idx_n, cnt, cnt_n, steps_r, steps_n;
  logic l_r, g_r, e_r, done_r, l_n, g_n, e_n, done_n;
  logic [CHUNK-1:0] ca, cb;
  assign ca = a_r[idx*CHUNK +: CHUNK];
  assign cb = b_r[idx*CHUNK +: CHUNK];
  assign bus.busy = (state == COMPARE);
  assign bus.done = done_r;
  assign bus.L = l_r;
  assign bus.G = g_r;
  assign bus.E = e_r;
  assign bus.steps = steps_r;
  always_comb begin
    state_n = state;
    a_n = a_r;
    b_n = b_r;
    idx_n = idx;
    cnt_n = cnt;
    l_n = l_r;
    g_n = g_r;
    e_n = e_r;
    steps_n = steps_r;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (bus.start) begin
        // flipping the sign bit at latch time turns a signed compare into an unsigned one
        a_n = bus.a ^ (bus.signed_mode ? MSB : '0);
        b_n = bus.b ^ (bus.signed_mode ? MSB : '0);
        idx_n = CW'(NCHUNK - 1);
        cnt_n = '0;
        state_n = COMPARE;
      end
    end else begin
      cnt_n = cnt + CW'(1);
      if (ca != cb || idx == '0) begin
        l_n = ca < cb;
        g_n = ca > cb;
        e_n = ca == cb;
        steps_n = cnt + CW'(1);
        done_n = 1'b1;
        state_n = IDLE;
      end else begin
        idx_n = idx - CW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      idx <= '0;
      cnt <= '0;
      l_r <= 1'b0;
      g_r <= 1'b0;
      e_r <= 1'b0;
      steps_r <= '0;
      done_r <= 1'b0;
    end else begin
      state <= state_n;
      a_r <= a_n;
      b_r <= b_n;
      idx <= idx_n;
      cnt <= cnt_n;
      l_r <= l_n;
      g_r <= g_n;
      e_r <= e_n;
      steps_r <= steps_n;
      done_r <= done_n;
    end
  end
endmodule

// File: tb/tb_mag_comp_serial.sv
// tb_mag_comp_serial: directed and random compares against an arithmetic reference model
module tb_mag_comp_serial;
  localparam int W = 16;
  localparam int CH = 4;
  localparam int NCH = W / CH;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int errs = 0;
  mag_comp_serial_if #(.WIDTH(W), .CHUNK(CH)) m ();
  mag_comp_serial #(.WIDTH(W), .CHUNK(CH)) dut (.clk(clk), .rst(rst), .bus(m));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  function automatic int ref_steps(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d;
    d = x ^ y;
    for (int i = W - 1; i >= 0; i--)
      if (d[i]) return NCH - i / CH;
    return NCH;
  endfunction
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsm, input int gap);
    int cyc;
    int ks;
    logic seen;
    logic el, eg, ee;
    m.start = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      if (g == 0) chk("done_single_pulse", m.done, 1'b0);
    end
    ks = ref_steps(ta, tb_v);
    eg = tsm ? ($signed(ta) > $signed(tb_v)) : (ta > tb_v);
    el = tsm ? ($signed(ta) < $signed(tb_v)) : (ta < tb_v);
    ee = (ta == tb_v);
    m.start = 1'b1;
    m.a = ta;
    m.b = tb_v;
    m.signed_mode = tsm;
    @(posedge clk);
    #1;
    chk("busy_after_start", m.busy, 1'b1);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < NCH + 2) begin
      m.start = 1'($urandom_range(0, 1));
      m.a = W'($urandom);
      m.b = W'($urandom);
      m.signed_mode = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      cyc++;
      if (m.done === 1'b1) seen = 1'b1;
    end
    m.start = 1'b0;
    chk("done_seen", seen, 1'b1);
    chk("latency", cyc, ks);
    chk("busy_in_done", m.busy, 1'b0);
    chk("L", m.L, el);
    chk("G", m.G, eg);
    chk("E", m.E, ee);
    chk("steps", m.steps, ks);
  endtask
  initial begin
    logic [W-1:0] ra, rb;
    logic any_done;
    int k;
    m.start = 1'b0;
    m.signed_mode = 1'b0;
    m.a = '0;
    m.b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", m.busy, 1'b0);
    chk("rst_done", m.done, 1'b0);
    chk("rst_LGE", {m.L, m.G, m.E}, 3'b000);
    chk("rst_steps", m.steps, 0);
    run_op(16'h1234, 16'h1234, 1'b0, 1);
    run_op(16'h8000, 16'h7FFF, 1'b0, 1);
    run_op(16'h8000, 16'h7FFF, 1'b1, 1);
    run_op(16'h12A4, 16'h12B4, 1'b0, 2);
    run_op(16'hFFFF, 16'hFFFE, 1'b1, 1);
    run_op(16'h0001, 16'h0002, 1'b1, 0);
    run_op(16'h0000, 16'h0001, 1'b0, 0);
    m.start = 1'b1;
    m.a = 16'h1111;
    m.b = 16'h1111;
    m.signed_mode = 1'b0;
    @(posedge clk);
    #1;
    m.start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", m.busy, 1'b0);
    chk("abort_done", m.done, 1'b0);
    chk("abort_LGE", {m.L, m.G, m.E}, 3'b000);
    chk("abort_steps", m.steps, 0);
    any_done = 1'b0;
    repeat (NCH + 1) begin
      @(posedge clk);
      #1;
      any_done = any_done | m.done;
    end
    chk("abort_no_done", any_done, 1'b0);
    run_op(16'h1111, 16'h1111, 1'b0, 1);
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      k = $urandom_range(0, 3);
      rb = k == 0 ? ra : k == 1 ? W'($urandom) : ra ^ (W'(1) << $urandom_range(0, W - 1));
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
